// File: rtl/rom_programmer.sv
// Fuse PROM word programmer for 556PT5/556PT4: checks blank state, pulses each
// missing bit with bounded retries, verifies by readback and reports pass/fail.
module rom_programmer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int PULSE_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_ATTEMPTS  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    bit_select,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               fail_code,
    output logic [3:0]               fail_bit
);

    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int ATT_W   = $clog2(MAX_ATTEMPTS) + 1;

    localparam logic [3:0] OP_OFF  = 4'b0000;
    localparam logic [3:0] OP_READ = 4'b1100;
    localparam logic [3:0] OP_PROG = 4'b1111;

    typedef enum logic [2:0] {
        IDLE, SETUP, CHECK, SELECT, PULSE, RECOVER, VERIFY, DONE
    } state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [ATT_W-1:0]        attempts, attempts_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   pending, pending_d;
    logic [BIT_W-1:0]        cur_bit, cur_bit_d;
    logic [ADDRESS_WIDTH-1:0] address_d;
    logic                    error_d;
    logic [1:0]              fail_code_d;
    logic [3:0]              fail_bit_d;
    logic [3:0]              operation_d;
    logic [DATA_WIDTH-1:0]   bit_select_d;
    logic [DATA_WIDTH-1:0]   overblown;

    function automatic logic [BIT_W-1:0] lowest_set(input logic [DATA_WIDTH-1:0] v);
        logic [BIT_W-1:0] idx;
        idx = '0;
        for (int unsigned i = DATA_WIDTH; i > 0; i--) begin
            if (v[i-1]) idx = BIT_W'(i - 1);
        end
        return idx;
    endfunction

    assign overblown = data_line_in & ~data_q;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        attempts_d  = attempts;
        data_d      = data_q;
        pending_d   = pending;
        cur_bit_d   = cur_bit;
        address_d   = address_line;
        error_d     = error;
        fail_code_d = fail_code;
        fail_bit_d  = fail_bit;

        case (state)
            IDLE: begin
                if (start) begin
                    address_d   = address_in;
                    data_d      = data_in;
                    error_d     = 1'b0;
                    fail_code_d = 2'b00;
                    fail_bit_d  = 4'd0;
                    cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) state_d = CHECK;
                else cnt_d = cnt - CNT_W'(1);
            end
            CHECK: begin
                if (overblown != '0) begin
                    error_d     = 1'b1;
                    fail_code_d = 2'b01;
                    fail_bit_d  = 4'(lowest_set(overblown));
                    state_d     = DONE;
                end else begin
                    pending_d = data_q & ~data_line_in;
                    state_d   = SELECT;
                end
            end
            SELECT: begin
                if (pending == '0) begin
                    state_d = DONE;
                end else begin
                    cur_bit_d  = lowest_set(pending);
                    attempts_d = ATT_W'(1);
                    cnt_d      = CNT_W'(PULSE_CYCLES - 1);
                    state_d    = PULSE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt == '0) state_d = VERIFY;
                else cnt_d = cnt - CNT_W'(1);
            end
            VERIFY: begin
                if (data_line_in[cur_bit]) begin
                    pending_d[cur_bit] = 1'b0;
                    state_d            = SELECT;
                end else if (attempts < ATT_W'(MAX_ATTEMPTS)) begin
                    attempts_d = attempts + ATT_W'(1);
                    cnt_d      = CNT_W'(PULSE_CYCLES - 1);
                    state_d    = PULSE;
                end else begin
                    error_d     = 1'b1;
                    fail_code_d = 2'b10;
                    fail_bit_d  = 4'(cur_bit);
                    state_d     = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state.
        operation_d  = OP_READ;
        bit_select_d = '0;
        case (state_d)
            IDLE:  operation_d = OP_OFF;
            PULSE: begin
                operation_d  = OP_PROG;
                bit_select_d = DATA_WIDTH'(1) << cur_bit_d;
            end
            default: operation_d = OP_READ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            attempts     <= '0;
            data_q       <= '0;
            pending      <= '0;
            cur_bit      <= '0;
            address_line <= '0;
            error        <= 1'b0;
            fail_code    <= 2'b00;
            fail_bit     <= 4'd0;
            operation    <= OP_OFF;
            bit_select   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            attempts     <= attempts_d;
            data_q       <= data_d;
            pending      <= pending_d;
            cur_bit      <= cur_bit_d;
            address_line <= address_d;
            error        <= error_d;
            fail_code    <= fail_code_d;
            fail_bit     <= fail_bit_d;
            operation    <= operation_d;
            bit_select   <= bit_select_d;
            busy         <= (state_d != IDLE);
            done         <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_rom_programmer.sv
// Scoreboard bench for rom_programmer with a behavioural fuse PROM model.
module tb_rom_programmer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] address_in = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_line_in;
    logic [3:0] operation;
    logic [8:0] address_line;
    logic [7:0] bit_select;
    logic       busy, done, error;
    logic [1:0] fail_code;
    logic [3:0] fail_bit;

    rom_programmer #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(9), .PULSE_CYCLES(16),
        .SETTLE_CYCLES(4), .MAX_ATTEMPTS(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .address_in(address_in),
        .data_in(data_in), .data_line_in(data_line_in), .operation(operation),
        .address_line(address_line), .bit_select(bit_select), .busy(busy),
        .done(done), .error(error), .fail_code(fail_code), .fail_bit(fail_bit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chip model: a fuse blows when a pulse ends, unless marked dead.
    logic [7:0] fuses = '0;
    logic [7:0] dead = '0;
    logic [7:0] pbs = '0;
    logic [7:0] load_val = '0;
    logic       load_req = 1'b0;
    assign data_line_in = fuses;

    always @(posedge clk) begin
        if (load_req) fuses <= load_val;
        else if (reset_n && pbs != 0 && bit_select == 0) fuses <= fuses | (pbs & ~dead);
        pbs <= bit_select;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         cyc;
        logic       err;
        logic [1:0] code;
        logic [3:0] fbit;
        logic [8:0] addr;
    } exp_t;

    exp_t sb[$];
    int   pq[$];
    int   done_cnt = 0;

    // Completion monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("error", error, e.err);
                chk("fail_code", fail_code, e.code);
                chk("fail_bit", fail_bit, e.fbit);
                chk("address_line", address_line, e.addr);
                chk("busy_at_done", busy, 1);
            end
        end
    end

    // Pulse monitor
    int         plen = 0;
    logic [7:0] pbit = '0;
    logic       pbad = 1'b0;
    always @(negedge clk) begin
        int eb;
        if (!reset_n) begin
            plen = 0;
            pbad = 1'b0;
        end else if (bit_select != 0) begin
            if (plen == 0) pbit = bit_select;
            else if (bit_select != pbit) pbad = 1'b1;
            if (operation != 4'b1111 || $countones(bit_select) != 1) pbad = 1'b1;
            plen++;
        end else if (plen != 0) begin
            if (pq.size() == 0) begin
                chk("unexpected_pulse", {24'd0, pbit}, 0);
            end else begin
                eb = pq.pop_front();
                chk("pulse_bit", {24'd0, pbit}, 32'd1 << eb);
                chk("pulse_len", plen, 16);
                chk("pulse_shape", {31'd0, pbad}, 0);
            end
            plen = 0;
            pbad = 1'b0;
        end
    end

    task automatic load_chip(input logic [7:0] v, input logic [7:0] d);
        dead     = d;
        load_val = v;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic issue(input logic [8:0] a, input logic [7:0] d, input bit push,
                         input int dly, input logic err, input logic [1:0] code,
                         input logic [3:0] fb, output int c0);
        exp_t e;
        address_in = a;
        data_in    = d;
        start      = 1'b1;
        c0         = cyc;
        if (push) begin
            e.cyc = c0 + dly; e.err = err; e.code = code; e.fbit = fb; e.addr = a;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && done_cnt < target; i++) @(negedge clk);
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int prev;

        repeat (3) @(negedge clk);
        chk("rst_operation", operation, 0);
        chk("rst_bit_select", bit_select, 0);
        chk("rst_address_line", address_line, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_fail_bit", fail_bit, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: blank chip, nothing to burn
        load_chip(8'h00, 8'h00);
        issue(9'h011, 8'h00, 1, 7, 1'b0, 2'b00, 4'd0, c0);
        wait_done(1);

        // 2: 0xA5 on a blank chip, one pulse per bit
        load_chip(8'h00, 8'h00);
        pq.push_back(0); pq.push_back(2); pq.push_back(5); pq.push_back(7);
        issue(9'h1A5, 8'hA5, 1, 95, 1'b0, 2'b00, 4'd0, c0);
        wait_done(2);
        chk("chip_after_a5", fuses, 8'hA5);

        // 3: overblown bit 0
        load_chip(8'h01, 8'h00);
        issue(9'h002, 8'h00, 1, 6, 1'b1, 2'b01, 4'd0, c0);
        wait_done(3);

        // 4: bit 3 never programs, 8 pulses then give up
        load_chip(8'h00, 8'h08);
        for (int i = 0; i < 8; i++) pq.push_back(3);
        issue(9'h0F3, 8'h08, 1, 175, 1'b1, 2'b10, 4'd3, c0);
        wait_done(4);

        // 5: reset in cycle 10 of the first pulse
        load_chip(8'h00, 8'h00);
        issue(9'h055, 8'h01, 0, 0, 1'b0, 2'b00, 4'd0, c0);
        while (cyc < c0 + 16) @(negedge clk);
        #2;
        chk("mid_pulse_bit_select", bit_select, 8'h01);
        reset_n = 1'b0;
        #1;
        chk("async_operation", operation, 0);
        chk("async_bit_select", bit_select, 0);
        chk("async_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_done_cnt", done_cnt, 4);
        load_chip(8'h00, 8'h00);
        pq.push_back(0);
        issue(9'h056, 8'h01, 1, 29, 1'b0, 2'b00, 4'd0, c0);
        wait_done(5);

        // 6: start and address changes while busy are ignored
        load_chip(8'h00, 8'h00);
        issue(9'h123, 8'h00, 1, 7, 1'b0, 2'b00, 4'd0, c0);
        address_in = 9'h0AA;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("addr_held_busy", address_line, 9'h123);
        prev = done_cnt;
        wait_done(prev + 1);
        repeat (10) @(negedge clk);
        chk("single_done", done_cnt, prev + 1);

        chk("sb_empty", sb.size(), 0);
        chk("pulse_q_empty", pq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
